// File: rtl/sa_skew_feeder.sv
// ---------------------------------------------------------------------------
// sa_skew_feeder
//   Operand sequencer for the 4x4 systolic MAC array. Holds one weight tile
//   (N rows) and K activation vectors locally. A start request loads the
//   weights into the array (hold=0), streams the activations with a diagonal
//   skew of one cycle per lane (hold=1), then drains zeros until the array
//   results are valid and pulses done.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset (clears outputs, FSM and store)
//   wr_en    write strobe for the local operand store (honoured only in idle)
//   wr_sel   0 = weight row store, 1 = activation vector store
//   wr_addr  row index (weights 0..N-1, activations 0..K-1)
//   wr_data  one row/vector, lane j = wr_data[j*DW +: DW]
//   start    single-cycle request to run a tile
//   w_out    weight lanes to the array (lane0 = w1)
//   a_out    activation lanes to the array (lane0 = a1)
//   hold     0 = array shifts weights, 1 = array holds weights and MACs
//   busy     high while a tile is in flight, including the done cycle
//   done     one-cycle pulse on the last drain cycle
// ---------------------------------------------------------------------------
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start, store writable
//   S_LOADW  | shifting weight rows N-1..0 into the array, hold=0
//   S_STREAM | skewed activation stream, K+N-1 cycles, hold=1
//   S_DRAIN  | zeros while the array flushes, done on last cycle
// ---------------------------------------------------------------------------
module sa_skew_feeder #(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int K     = 8,
    parameter int DRAIN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [3:0]      wr_addr,
    input  logic [N*DW-1:0] wr_data,
    input  logic            start,
    output logic [N*DW-1:0] w_out,
    output logic [N*DW-1:0] a_out,
    output logic            hold,
    output logic            busy,
    output logic            done
);

    // Counter sized so the longest phase never wraps (4 bits at defaults).
    localparam int CSPAN = (K + N > DRAIN + 1) ? (K + N) : (DRAIN + 1);
    localparam int CW    = $clog2(CSPAN);
    localparam int WAW   = (N > 1) ? $clog2(N) : 1;
    localparam int AAW   = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADW  = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic [N*DW-1:0] wmem [N];
    logic [N*DW-1:0] amem [K];

    logic [N*DW-1:0] w_nxt, a_nxt;
    logic            hold_nxt, busy_nxt, done_nxt;
    logic            accept;

    // Outputs lag the FSM by one register, so the FSM is already back in
    // S_IDLE while the done pulse is still visible. Gating on the busy flop
    // keeps start and writes ignored during that done cycle as well.
    assign accept = (state == S_IDLE) && !busy;

    // ---------------- operand store ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) wmem[i] <= '0;
            for (int i = 0; i < K; i++) amem[i] <= '0;
        end else if (wr_en && accept) begin
            if (!wr_sel) begin
                if (int'(wr_addr) < N) wmem[WAW'(wr_addr)] <= wr_data;
            end else begin
                if (int'(wr_addr) < K) amem[AAW'(wr_addr)] <= wr_data;
            end
        end
    end

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---------------- next state and output decode ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        w_nxt     = '0;
        a_nxt     = '0;
        hold_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start && accept) begin
                    state_nxt = S_LOADW;
                    cnt_nxt   = '0;
                end
            end

            S_LOADW: begin
                busy_nxt = 1'b1;
                // Deepest row first so row 0 ends up in the top array row.
                w_nxt = wmem[WAW'(N - 1 - int'(cnt))];
                if (cnt == CW'(N - 1)) begin
                    state_nxt = S_STREAM;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_STREAM: begin
                busy_nxt = 1'b1;
                hold_nxt = 1'b1;
                for (int j = 0; j < N; j++) begin
                    automatic int t = int'(cnt) - j;
                    if (t >= 0 && t < K)
                        a_nxt[j*DW +: DW] = amem[AAW'(t)][j*DW +: DW];
                end
                if (cnt == CW'(K + N - 2)) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_DRAIN: begin
                busy_nxt = 1'b1;
                hold_nxt = 1'b1;
                if (cnt == CW'(DRAIN - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_out <= '0;
            a_out <= '0;
            hold  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            w_out <= w_nxt;
            a_out <= a_nxt;
            hold  <= hold_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Testbench for sa_skew_feeder: scoreboard of expected per-cycle outputs,
// pushed when a tile is started and popped on every falling edge.
module tb_sa_skew_feeder;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int K     = 8;
    localparam int DRAIN = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en, wr_sel, start;
    logic [3:0]      wr_addr;
    logic [N*DW-1:0] wr_data;
    logic [N*DW-1:0] w_out, a_out;
    logic            hold, busy, done;

    sa_skew_feeder #(.DW(DW), .N(N), .K(K), .DRAIN(DRAIN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .w_out   (w_out),
        .a_out   (a_out),
        .hold    (hold),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] w;
        logic [N*DW-1:0] a;
        logic            hold;
        logic            busy;
        logic            done;
    } exp_t;

    exp_t            q[$];
    exp_t            e_mon;
    logic [N*DW-1:0] wm [N];
    logic [N*DW-1:0] am [K];

    int    total = 0;
    int    bad   = 0;
    int    neg_cnt = 0;
    int    busy_cnt = 0;
    int    done_cnt = 0;
    int    done_at = 0;
    int    start_at = 0;
    string phase = "reset";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [N*DW-1:0] w, input logic [N*DW-1:0] a,
                                input logic h, input logic b, input logic d);
        exp_t r;
        r.w = w; r.a = a; r.hold = h; r.busy = b; r.done = d;
        return r;
    endfunction

    // Expected output windows: the start cycle, the cycle after the start
    // edge, then N load + K+N-1 stream + DRAIN cycles.
    task automatic push_tile();
        logic [N*DW-1:0] a;
        q.push_back(mk('0, '0, 0, 0, 0));
        q.push_back(mk('0, '0, 0, 0, 0));
        for (int c = 0; c < N; c++) q.push_back(mk(wm[N-1-c], '0, 0, 1, 0));
        for (int t = 0; t < K + N - 1; t++) begin
            a = '0;
            for (int j = 0; j < N; j++)
                if (t - j >= 0 && t - j < K) a[j*DW +: DW] = am[t-j][j*DW +: DW];
            q.push_back(mk('0, a, 1, 1, 0));
        end
        for (int d = 0; d < DRAIN; d++) q.push_back(mk('0, '0, 1, 1, d == DRAIN - 1));
    endtask

    always @(negedge clk) begin
        neg_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_at = neg_cnt;
        end
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            check_eq({phase, ".w_out"}, w_out, e_mon.w);
            check_eq({phase, ".a_out"}, a_out, e_mon.a);
            check_eq({phase, ".hold"},  32'(hold), 32'(e_mon.hold));
            check_eq({phase, ".busy"},  32'(busy), 32'(e_mon.busy));
            check_eq({phase, ".done"},  32'(done), 32'(e_mon.done));
        end
    end

    task automatic write_row(input logic sel, input logic [3:0] addr, input logic [N*DW-1:0] data);
        @(posedge clk); #1;
        wr_en = 1; wr_sel = sel; wr_addr = addr; wr_data = data;
        if (!sel && int'(addr) < N) wm[addr] = data;
        if (sel && int'(addr) < K)  am[addr] = data;
        @(posedge clk); #1;
        wr_en = 0;
    endtask

    task automatic begin_tile(input bit do_wr, input logic sel, input logic [3:0] addr,
                              input logic [N*DW-1:0] data);
        @(posedge clk); #1;
        start = 1;
        if (do_wr) begin
            wr_en = 1; wr_sel = sel; wr_addr = addr; wr_data = data;
            if (!sel && int'(addr) < N) wm[addr] = data;
            if (sel && int'(addr) < K)  am[addr] = data;
        end
        busy_cnt = 0;
        done_cnt = 0;
        start_at = neg_cnt;
        push_tile();
        @(posedge clk); #1;
        start = 0;
        wr_en = 0;
    endtask

    task automatic finish_tile();
        int n;
        q.push_back(mk('0, '0, 0, 0, 0));
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq({phase, ".sb_empty"}, 32'(q.size()), 0);
        check_eq({phase, ".busy_cycles"}, 32'(busy_cnt), 19);
        check_eq({phase, ".done_pulses"}, 32'(done_cnt), 1);
        check_eq({phase, ".done_latency"}, 32'(done_at - start_at - 1), 20);
    endtask

    initial begin
        rst_n = 0; wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0; start = 0;
        for (int i = 0; i < N; i++) wm[i] = '0;
        for (int i = 0; i < K; i++) am[i] = '0;

        #12;
        check_eq("reset.w_out", w_out, 0);
        check_eq("reset.a_out", a_out, 0);
        check_eq("reset.busy", 32'(busy), 0);
        check_eq("reset.done", 32'(done), 0);
        check_eq("reset.hold", 32'(hold), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;

        write_row(0, 4'd0, {8'd4, 8'd3, 8'd2, 8'd1});
        write_row(0, 4'd1, {8'd8, 8'd7, 8'd6, 8'd5});
        write_row(0, 4'd2, {8'd4, 8'd3, 8'd2, 8'd1});
        write_row(0, 4'd3, {8'd8, 8'd7, 8'd6, 8'd5});
        for (int i = 0; i < K; i++) write_row(1, 4'(i), {4{8'(8 - i)}});
        write_row(0, 4'd5, 32'hDEADBEEF);
        write_row(1, 4'd8, 32'hCAFEF00D);

        // weight load, skew and timing
        phase = "tile";
        begin_tile(0, 0, '0, '0);
        finish_tile();

        // writes while busy are dropped
        phase = "wr_busy";
        begin_tile(0, 0, '0, '0);
        repeat (5) @(posedge clk);
        #1;
        wr_en = 1; wr_sel = 1; wr_addr = 4'd0; wr_data = 32'hAAAAAAAA;
        @(posedge clk); #1;
        wr_sel = 0; wr_data = 32'h55555555;
        @(posedge clk); #1;
        wr_en = 0;
        finish_tile();

        // write and start in the same idle cycle
        phase = "wr_start";
        begin_tile(1, 1, 4'd0, {4{8'd9}});
        finish_tile();
        write_row(1, 4'd0, {4{8'd8}});

        // start during busy and on the done cycle is ignored
        phase = "b2b_a";
        begin_tile(0, 0, '0, '0);
        repeat (3) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        repeat (15) @(posedge clk);
        #1 start = 1;
        @(negedge clk); #1;
        check_eq("b2b_a.busy_cycles", 32'(busy_cnt), 19);
        check_eq("b2b_a.done_pulses", 32'(done_cnt), 1);
        phase = "b2b_b";
        begin_tile(0, 0, '0, '0);
        finish_tile();

        // asynchronous reset in the middle of the stream
        phase = "rst_mid";
        begin_tile(0, 0, '0, '0);
        repeat (8) @(posedge clk);
        #2 rst_n = 0;
        q.delete();
        #1;
        check_eq("rst_mid.w_out", w_out, 0);
        check_eq("rst_mid.a_out", a_out, 0);
        check_eq("rst_mid.busy", 32'(busy), 0);
        check_eq("rst_mid.done", 32'(done), 0);
        check_eq("rst_mid.hold", 32'(hold), 0);
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(negedge clk);
        check_eq("rst_mid.idle_busy", 32'(busy), 0);
        check_eq("rst_mid.no_done", 32'(done_cnt), 0);
        for (int i = 0; i < N; i++) wm[i] = '0;
        for (int i = 0; i < K; i++) am[i] = '0;
        phase = "post_rst";
        begin_tile(0, 0, '0, '0);
        finish_tile();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
